// File: rtl/uart_tx_fsm_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm_pkg
// Shared definitions for the UART transmitter. The state encodings and
// prescale codes use the same values as the oversampling UART receiver.
//
// Contents:
//   tx_state_e         FSM state encoding (Idle/Start/Data/Parity/Stop)
//   PRESCALE_*         Prescale input codes
//   BIT_LEN_*          bit length in clocks for each prescale code
//   bit_last()         terminal edge-count value (N-1) for a prescale code
//
// Configuration macro: UART_TX_PARITY_EN (used by the files importing this).
// -----------------------------------------------------------------------------
package uart_tx_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b111,
    ST_STOP   = 3'b110
  } tx_state_e;

  localparam logic [1:0] PRESCALE_8  = 2'b00;
  localparam logic [1:0] PRESCALE_16 = 2'b01;
  localparam logic [1:0] PRESCALE_32 = 2'b10;

  localparam int unsigned BIT_LEN_8  = 8;
  localparam int unsigned BIT_LEN_16 = 16;
  localparam int unsigned BIT_LEN_32 = 32;

  // Codes 10 and 11 both select 32 clocks per bit.
  function automatic logic [4:0] bit_last(input logic [1:0] code);
    logic [4:0] last;
    case (code)
      PRESCALE_8:  last = 5'(BIT_LEN_8 - 1);
      PRESCALE_16: last = 5'(BIT_LEN_16 - 1);
      default:     last = 5'(BIT_LEN_32 - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Load/shift register for the UART transmitter, plus parity generation.
// ser_bit is always the next data bit the FSM will put on the line: the FSM
// samples it and pulses shift on the same edge, so the register stays one
// bit ahead of the line.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous reset, active-low (parity flop only)
//   load     in   capture data and compute parity
//   shift    in   shift the register right by one bit
//   data     in   DATA_WIDTH parallel word
//   par_typ  in   0 = even, 1 = odd
//   ser_bit  out  current register LSB
//   par_bit  out  parity bit computed at load
//
// Configuration macro: UART_TX_PARITY_EN (parity logic removed when undefined).
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  ser_bit,
  output logic                  par_bit
);

  logic [DATA_WIDTH-1:0] shreg;

  // Datapath register: no reset, its contents are only meaningful after load.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
    end
  end

  assign ser_bit = shreg[0];

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^data) ^ par_typ;
    end
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = par_typ & rst;
  assign par_bit     = 1'b0;
`endif

endmodule

// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
// UART transmitter: serializes one DATA_WIDTH word into a
// start / data (LSB first) / [parity] / stop frame. Each bit lasts N clocks,
// N = 8/16/32 chosen by Prescale. Settings are latched when a request is
// accepted, so mid-frame input changes have no effect.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous reset, active-low
//   P_DATA      in   DATA_WIDTH word to send
//   DATA_VALID  in   send request (ignored while Busy)
//   PAR_EN      in   parity enable
//   PAR_TYP     in   parity type, 0 = even, 1 = odd
//   Prescale    in   00 -> 8, 01 -> 16, 1x -> 32 clocks per bit
//   TX_OUT      out  serial line, idle high (registered)
//   Busy        out  frame in progress (registered)
//
// Configuration macro: UART_TX_PARITY_EN. When undefined the Parity state is
// removed, PAR_EN/PAR_TYP are ignored and every frame is 2 + DATA_WIDTH bits.
// -----------------------------------------------------------------------------
module uart_tx_fsm
  import uart_tx_fsm_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int Counter_Size = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [1:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  tx_state_e               state;
  logic [Counter_Size-1:0] edge_cnt;
  logic [Counter_Size-1:0] bit_last_q;
  logic [BitCntW-1:0]      bit_cnt;
  logic                    edge_done;
  logic                    load;
  logic                    shift;
  logic                    ser_bit;
  logic                    par_bit;
  logic                    par_typ_sel;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  assign par_typ_sel = PAR_TYP;
`else
  logic unused_par;
  assign unused_par  = PAR_EN ^ PAR_TYP ^ par_bit;
  assign par_typ_sel = 1'b0;
`endif

  assign edge_done = (edge_cnt == bit_last_q);
  assign load      = (state == ST_IDLE) && DATA_VALID;
  // The register advances at the end of Start and of every data bit, so that
  // ser_bit already holds the bit the FSM registers onto the line next.
  assign shift     = edge_done && ((state == ST_START) || (state == ST_DATA));

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .data   (P_DATA),
    .par_typ(par_typ_sel),
    .ser_bit(ser_bit),
    .par_bit(par_bit)
  );

  // TX_OUT and Busy are assigned on the transition into each state, so the
  // registered line value always matches the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      bit_last_q <= Counter_Size'(bit_last(PRESCALE_8));
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (DATA_VALID) begin
            bit_last_q <= Counter_Size'(bit_last(Prescale));
`ifdef UART_TX_PARITY_EN
            par_en_q   <= PAR_EN;
`endif
            state      <= ST_START;
            TX_OUT     <= 1'b0;
            Busy       <= 1'b1;
          end
        end

        ST_START: begin
          if (edge_done) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
            TX_OUT   <= ser_bit;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (edge_done) begin
            edge_cnt <= '0;
            if (bit_cnt == LastBit) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state  <= ST_PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= ST_STOP;
                TX_OUT <= 1'b1;
              end
`else
              state  <= ST_STOP;
              TX_OUT <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              TX_OUT  <= ser_bit;
            end
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (edge_done) begin
            edge_cnt <= '0;
            state    <= ST_STOP;
            TX_OUT   <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (edge_done) begin
            edge_cnt <= '0;
            state    <= ST_IDLE;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

        // Illegal encodings recover to Idle.
        default: begin
          state    <= ST_IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fsm
// Directed bench for uart_tx_fsm. Expected frames are hand-written words in
// which bit i is the i-th bit on the line (start = bit 0). Expectations follow
// UART_TX_PARITY_EN so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_fsm #(
    .DATA_WIDTH  (8),
    .Counter_Size(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; returns in the first cycle after the accept edge.
  task automatic accept(input logic [7:0] d);
    DATA_VALID = 1'b1;
    P_DATA     = d;
    step();
    DATA_VALID = 1'b0;
  endtask

  // Walks a whole frame from the first cycle after accept, then checks the
  // single idle cycle that follows. At inj_cycle (if >= 0) a new request with
  // a different word and prescale is raised and left held.
  task automatic check_frame(input string tag, input logic [15:0] frame,
                             input int nbits, input int n, input int inj_cycle,
                             input logic [7:0] inj_data, input logic [1:0] inj_pre);
    for (int k = 0; k < nbits * n; k++) begin
      if (k == inj_cycle) begin
        DATA_VALID = 1'b1;
        P_DATA     = inj_data;
        Prescale   = inj_pre;
      end
      check_bit($sformatf("%s_busy@%0d", tag, k), Busy, 1'b1);
      check_bit($sformatf("%s_tx@%0d", tag, k), TX_OUT, frame[k / n]);
      step();
    end
    check_bit($sformatf("%s_end_busy", tag), Busy, 1'b0);
    check_bit($sformatf("%s_end_tx", tag), TX_OUT, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 2'b00;

    // Reset state
    step();
    step();
    check_bit("reset_tx", TX_OUT, 1'b1);
    check_bit("reset_busy", Busy, 1'b0);
    rst = 1'b1;
    step();
    check_bit("post_reset_tx", TX_OUT, 1'b1);
    check_bit("post_reset_busy", Busy, 1'b0);

    // No parity, 0xA5, 8 clocks per bit: 0,1,0,1,0,0,1,0,1,1 -> 80 cycles
    Prescale = 2'b00;
    PAR_EN   = 1'b0;
    accept(8'hA5);
    check_frame("nopar_a5", 16'h034A, 10, 8, -1, 8'h00, 2'b00);
    step();

    // Even parity, 0x0F, 16 clocks per bit: parity 0 -> 176 cycles
    Prescale = 2'b01;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    accept(8'h0F);
`ifdef UART_TX_PARITY_EN
    check_frame("even_0f", 16'h041E, 11, 16, -1, 8'h00, 2'b01);
`else
    check_frame("even_0f", 16'h021E, 10, 16, -1, 8'h00, 2'b01);
`endif
    step();

    // Odd parity, 0x07, 32 clocks per bit: parity 0 -> 352 cycles
    Prescale = 2'b10;
    PAR_TYP  = 1'b1;
    accept(8'h07);
`ifdef UART_TX_PARITY_EN
    check_frame("odd_07", 16'h040E, 11, 32, -1, 8'h00, 2'b10);
`else
    check_frame("odd_07", 16'h020E, 10, 32, -1, 8'h00, 2'b10);
`endif
    step();

    // Even parity, 0x07, 8 clocks per bit: parity 1
    Prescale = 2'b00;
    PAR_TYP  = 1'b0;
    accept(8'h07);
`ifdef UART_TX_PARITY_EN
    check_frame("even_07", 16'h060E, 11, 8, -1, 8'h00, 2'b00);
`else
    check_frame("even_07", 16'h020E, 10, 8, -1, 8'h00, 2'b00);
`endif
    step();

    // Request while busy: 0x3C (with prescale 01) raised mid-data and held.
    // Frame of 0xA5 unaffected; 0x3C accepted at T0+81, start bit at T0+82.
    PAR_EN   = 1'b0;
    Prescale = 2'b00;
    accept(8'hA5);
    check_frame("busy_a5", 16'h034A, 10, 8, 30, 8'h3C, 2'b01);
    step();
    DATA_VALID = 1'b0;
    check_frame("next_3c", 16'h0278, 10, 16, -1, 8'h00, 2'b01);
    step();

    // Reset mid-frame during data bit 3 (line cycles 32..39 of the frame)
    Prescale = 2'b00;
    accept(8'hA5);
    for (int k = 0; k < 34; k++) step();
    check_bit("pre_rst_busy", Busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_bit("async_rst_tx", TX_OUT, 1'b1);
    check_bit("async_rst_busy", Busy, 1'b0);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_bit($sformatf("idle_after_rst_tx@%0d", k), TX_OUT, 1'b1);
      check_bit($sformatf("idle_after_rst_busy@%0d", k), Busy, 1'b0);
      step();
    end

    // PAR_EN=1, 0x55, 8 clocks per bit (10 bits when parity compiled out)
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    accept(8'h55);
`ifdef UART_TX_PARITY_EN
    check_frame("cfg_55", 16'h04AA, 11, 8, -1, 8'h00, 2'b00);
`else
    check_frame("cfg_55", 16'h02AA, 10, 8, -1, 8'h00, 2'b00);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
